incr_arbiter: RTL and testbench
===============================

# incr_arbiter

Round-robin controller that shares one increment-and-check counter datapath between `NUM_REQ` requesters. Each grant increments the shared counter by one. The cycle after each grant, the block reports an even/odd check of the pre-increment value, plus a saturating count of odd checks. It sits between requesting agents and the shared counter, and replaces free-running increments with sequenced, arbitrated ones whose parity check is always sampled before the increment.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (≥2).
- `CNT_W`, 8: shared counter width.
- `ERR_W`, 4: odd-check counter width.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: when low, no new grants are issued; an in-flight grant/check completes.
- `req` in `NUM_REQ`: level requests, one bit per requester.
- `gnt` out `NUM_REQ`: one-hot grant, one-cycle pulse, registered.
- `count` out `CNT_W`: shared counter value.
- `chk_valid` out 1: one-cycle pulse, check result valid.
- `chk_even` out 1: pre-increment value was even; valid with `chk_valid`.
- `chk_id` out `$clog2(NUM_REQ)`: index of the requester whose grant produced the check.
- `odd_cnt` out `ERR_W`: saturating count of checks with `chk_even`=0.
- `busy` out 1: high in GRANT or CHECK.

## Operation
- FSM states:
  - IDLE → GRANT when `en` and `|req`.
  - GRANT → CHECK unconditionally.
  - CHECK → GRANT when `en` and `|req`, else IDLE.
- Arbitration:
  - Round-robin. The search starts at `last+1` mod `NUM_REQ`. `last` updates on every grant.
  - Reset `last`=`NUM_REQ-1`, so `req[0]` has first priority.
- `req` is sampled on the edge that enters GRANT. The winner's `gnt` bit is high for the whole GRANT cycle.
- On the edge leaving GRANT:
  - `count` ← `count`+1, modulo 2^`CNT_W`. `2^CNT_W-1` wraps to 0 with no flag.
  - `chk_even` ← ~`count[0]` (pre-increment value).
  - `chk_id` ← winner index.
  - `chk_valid` ← 1.
- `odd_cnt` increments on the same edge when the pre-increment value is odd. It saturates at `2^ERR_W-1`.
- Requester handshake:
  - A requester may deassert `req` in the cycle after `gnt`.
  - If `req` is still high at the next sampling point, it is treated as a new request and competes normally.
  - A requester that drops `req` before being granted is simply skipped; this is legal.
- `en` low during GRANT: the grant, increment and check still complete, then the FSM goes to IDLE.

## Timing
- Reset values: `gnt`=0, `count`=0, `chk_valid`=0, `chk_even`=0, `chk_id`=0, `odd_cnt`=0, `busy`=0, state=IDLE, `last`=`NUM_REQ-1`.
- Reset mid-operation, in any state: all of the above take their reset values immediately (async). No partial increment survives.
- Latency:
  - `req` high in cycle t (IDLE) → `gnt` in t+1.
  - New `count` and `chk_valid` in t+2.
- Throughput: under continuous requests, grants occur every 2 cycles (GRANT/CHECK alternate). At most one increment per 2 cycles.
- Outputs are registered: `gnt`, `chk_*`, `odd_cnt`, `busy` and `count` are all driven from flops, with no combinational path from `req`.

## Structure
- Package `incr_arb_pkg`:
  - State enum `arb_state_e` {IDLE, GRANT, CHECK}.
  - Default parameter constants.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req`, `last`.
  - Outputs: one-hot grant and index.
  - Instantiated once; reusable elsewhere.

## Test plan
- Reset then idle: all outputs 0 and `busy`=0 over 10 cycles. Assert `rst` mid-GRANT → `gnt`, `count`, `chk_valid` cleared in the same cycle.
- Single `req[0]` pulse at cycle t, `count`=0:
  - `gnt`=0001 at t+1.
  - `count`=1, `chk_valid`=1, `chk_even`=1, `chk_id`=0 at t+2.
  - Second request: `chk_even`=0, `odd_cnt`=1.
- All `req`=1111 held: grant order 0,1,2,3,0 on cycles t+1, t+3, t+5, t+7, t+9; `count`=5 after the fifth check; `odd_cnt`=2.
- `CNT_W`=3, `count`=7, one request: `count`→0, `chk_even`=0; no other side effect.
- `ERR_W`=2, 8 continuous grants from `count`=0: `odd_cnt` saturates at 3.
- `en` low with pending requests: no `gnt`. `en` dropped during GRANT → check completes, then IDLE; `busy`=0 one cycle after `chk_valid`.

Source files
------------

// File: rtl/incr_arbiter_pkg.sv
// Shared types and default sizing for the arbitrated increment-and-check block.
package incr_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_ERR_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    CHECK = 2'd2
  } arb_state_e;

endpackage

// File: rtl/incr_arbiter_rr_pick.sv
// Combinational round-robin picker: searches from last+1 upward (mod NUM_REQ)
// and returns the first asserted request as a one-hot vector and an index.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               any,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic [IDX_W-1:0] cand;

  // Walk the requesters in rotated priority order and keep the first hit.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last) + k) % NUM_REQ);
      if (!any && req[cand]) begin
        any          = 1'b1;
        gnt_oh[cand] = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/incr_arbiter.sv
// Round-robin sharing of one counter: each grant increments the counter once,
// and the cycle after the grant reports the parity of the pre-increment value.
module incr_arbiter
  import incr_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  parameter  int CNT_W   = DEF_CNT_W,
  parameter  int ERR_W   = DEF_ERR_W,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [CNT_W-1:0]   count,
  output logic               chk_valid,
  output logic               chk_even,
  output logic [IDX_W-1:0]   chk_id,
  output logic [ERR_W-1:0]   odd_cnt,
  output logic               busy
);

  arb_state_e           state;
  logic [IDX_W-1:0]     last;
  logic                 pick_any;
  logic [NUM_REQ-1:0]   pick_oh;
  logic [IDX_W-1:0]     pick_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req     (req),
    .last    (last),
    .any     (pick_any),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx)
  );

  // Sequencer: grant, then increment and report the check, then re-arbitrate.
  // 'last' doubles as the current winner, so chk_id is taken from it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      count     <= '0;
      chk_valid <= 1'b0;
      chk_even  <= 1'b0;
      chk_id    <= '0;
      odd_cnt   <= '0;
      busy      <= 1'b0;
      last      <= IDX_W'(NUM_REQ - 1);
    end else begin
      gnt       <= '0;
      chk_valid <= 1'b0;
      case (state)
        IDLE, CHECK: begin
          if (en && pick_any) begin
            state <= GRANT;
            gnt   <= pick_oh;
            last  <= pick_idx;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        GRANT: begin
          state     <= CHECK;
          count     <= count + 1'b1;
          chk_even  <= ~count[0];
          chk_id    <= last;
          chk_valid <= 1'b1;
          if (count[0] && (odd_cnt != '1)) begin
            odd_cnt <= odd_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_incr_arbiter.sv
// Scoreboard bench for incr_arbiter: a transaction-level model predicts each
// grant and its check; a negedge monitor pops and compares cycle by cycle.
module tb_incr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 8;
  localparam int ERR_W   = 4;
  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int CNT_MOD = 1 << CNT_W;
  localparam int ODD_MAX = (1 << ERR_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en  = 1'b0;
  logic [NUM_REQ-1:0] req = '0;
  logic [NUM_REQ-1:0] gnt;
  logic [CNT_W-1:0]   count;
  logic               chk_valid;
  logic               chk_even;
  logic [IDX_W-1:0]   chk_id;
  logic [ERR_W-1:0]   odd_cnt;
  logic               busy;

  incr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .CNT_W   (CNT_W),
    .ERR_W   (ERR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .count     (count),
    .chk_valid (chk_valid),
    .chk_even  (chk_even),
    .chk_id    (chk_id),
    .odd_cnt   (odd_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int id;
  } gnt_exp_t;

  typedef struct {
    int cyc;
    int id;
    bit even;
    int cnt;
    int odd;
  } chk_exp_t;

  gnt_exp_t gq[$];
  chk_exp_t cq[$];

  int n_cmp = 0;
  int n_bad = 0;

  int cyc;
  int m_count;
  int m_odd;
  int m_last;
  int busy_left;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic e);
    req = r;
    en  = e;
    @(negedge clk);
  endtask

  // Reference model: a new grant may be decided on any edge that does not
  // immediately follow a grant; the winner is the first requester after the
  // previous winner, and its check reports the counter parity before adding one.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc       = 0;
      m_count   = 0;
      m_odd     = 0;
      m_last    = NUM_REQ - 1;
      busy_left = 0;
      gq.delete();
      cq.delete();
    end else begin
      cyc++;
      if (busy_left != 2 && en && (req != '0)) begin
        int w;
        w = -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
          int c;
          c = (m_last + k) % NUM_REQ;
          if (w < 0 && req[c]) w = c;
        end
        m_last = w;
        gq.push_back('{cyc: cyc, id: w});
        if (m_count % 2 == 1 && m_odd < ODD_MAX) m_odd++;
        cq.push_back('{cyc: cyc, id: w, even: (m_count % 2 == 0),
                       cnt: (m_count + 1) % CNT_MOD, odd: m_odd});
        m_count   = (m_count + 1) % CNT_MOD;
        busy_left = 2;
      end else if (busy_left > 0) begin
        busy_left--;
      end
    end
  end

  // Monitor: compare grant, check and busy outputs against the queued predictions.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("busy", 32'(busy), 32'(busy_left > 0));
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
        gnt_exp_t g;
        logic [NUM_REQ-1:0] oh;
        g  = gq.pop_front();
        oh = '0;
        oh[g.id] = 1'b1;
        checkOutput("gnt", 32'(gnt), 32'(oh));
      end else begin
        checkOutput("gnt_quiet", 32'(gnt), 32'd0);
      end
      if (cq.size() > 0 && cq[0].cyc + 1 == cyc) begin
        chk_exp_t c;
        c = cq.pop_front();
        checkOutput("chk_valid", 32'(chk_valid), 32'd1);
        checkOutput("chk_even", 32'(chk_even), 32'(c.even));
        checkOutput("chk_id", 32'(chk_id), 32'(c.id));
        checkOutput("count", 32'(count), 32'(c.cnt));
        checkOutput("odd_cnt", 32'(odd_cnt), 32'(c.odd));
      end else begin
        checkOutput("chk_valid_quiet", 32'(chk_valid), 32'd0);
      end
    end
  end

  task automatic idleCheck(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus('0, 1'b1);
      checkOutput("idle_outputs", 32'({gnt, count, chk_valid, chk_even, chk_id, odd_cnt, busy}), 32'd0);
    end
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    applyStimulus('0, 1'b0);
    applyStimulus('0, 1'b0);
    applyStimulus('0, 1'b0);
    rst = 1'b0;
    idleCheck(10);

    // Two single requests from requester 0: even then odd check.
    applyStimulus(4'b0001, 1'b1);
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b1);
    applyStimulus(4'b0001, 1'b1);
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b1);

    // All requesters held: rotation through every index.
    for (int i = 0; i < 12; i++) applyStimulus(4'b1111, 1'b1);
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b1);

    // Random requests and enable.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(NUM_REQ'($urandom), ($urandom_range(0, 3) != 0));
    end

    // Reset asserted while a grant is on the wires.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      applyStimulus(4'b1010, 1'b1);
      if (gnt != '0) found = 1'b1;
    end
    checkOutput("rst_mid_grant_reached", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_async_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_async_count", 32'(count), 32'd0);
    checkOutput("rst_async_chk_valid", 32'(chk_valid), 32'd0);
    checkOutput("rst_async_busy", 32'(busy), 32'd0);
    checkOutput("rst_async_odd_cnt", 32'(odd_cnt), 32'd0);
    @(negedge clk);
    applyStimulus(4'b1111, 1'b1);
    rst = 1'b0;
    idleCheck(10);

    // Enable low with pending requests, then enable dropped during GRANT.
    for (int i = 0; i < 6; i++) applyStimulus(4'b1111, 1'b0);
    applyStimulus(4'b0110, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(4'b0110, 1'b0);

    // Continuous traffic: counter wraps and odd count saturates.
    for (int i = 0; i < 1200; i++) begin
      logic [NUM_REQ-1:0] r;
      r = NUM_REQ'($urandom);
      if (r == '0) r = 4'b0100;
      applyStimulus(r, 1'b1);
    end

    for (int i = 0; i < 5; i++) applyStimulus('0, 1'b1);
    checkOutput("queues_drained", 32'(gq.size() + cq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
